n64_vtiming_ext: RTL and testbench

N64_VTIMING_EXT -- requirements
Module: n64_vtiming_ext

---
 rtl/n64_vtiming_ext.sv | 163 ++++++++++++++++
 tb/tb_n64_vtiming_ext.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vtiming_ext.sv
// rtl/n64_vtiming_ext.sv - N64 field classifier (PAL/480i) with lock filter; N64_VINFO_LINECNT_EN exposes field line count
module n64_vtiming_ext #(
    parameter int LINE_CNT_W  = 10,
    parameter int PAL_LINE_TH = 288,
    parameter int LOCK_FRAMES = 3
) (
    input  logic                  VCLK,
    input  logic                  RST,
    input  logic                  nVDSYNC,
    input  logic [3:0]            Sync_pre,
    input  logic [3:0]            Sync_cur,
    output logic [1:0]            vinfo_o,
    output logic                  vinfo_locked_o,
    output logic                  vinfo_chg_o,
    output logic [LINE_CNT_W-1:0] field_lines_o
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [LINE_CNT_W-1:0] LINE_MAX  = {LINE_CNT_W{1'b1}};
    localparam logic [3:0]            LOCK_TH   = 4'(LOCK_FRAMES);
    localparam logic [1:0]            VINFO_RST = 2'b01;

    logic sample_en;
    logic pos_v;
    logic neg_v;
    logic pos_h;
    logic neg_h;
    logic sync_unused;

    assign sample_en   = !nVDSYNC;
    assign pos_v       = !Sync_pre[3] &&  Sync_cur[3];
    assign neg_v       =  Sync_pre[3] && !Sync_cur[3];
    assign pos_h       = !Sync_pre[1] &&  Sync_cur[1];
    assign neg_h       =  Sync_pre[1] && !Sync_cur[1];
    assign sync_unused = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

    logic [LINE_CNT_W-1:0] line_cnt;
    logic                  pal_cand;
    logic                  frame_id;
    logic                  pal_hit;

    // Compare in 32 bits so a threshold wider than the counter simply never hits.
    assign pal_hit = 32'(line_cnt) >= 32'(PAL_LINE_TH);

    always_ff @(posedge VCLK) begin
        if (RST) begin
            line_cnt <= '0;
            pal_cand <= 1'b0;
            frame_id <= 1'b0;
        end else if (sample_en) begin
            if (pos_v) begin
                line_cnt <= '0;
                pal_cand <= pal_hit;
            end else if (pos_h && (line_cnt != LINE_MAX)) begin
                line_cnt <= line_cnt + 1'b1;
            end
            if (neg_v) begin
                frame_id <= neg_h;
            end
        end
    end

    logic       field_evt;
    logic [1:0] cand;

    assign field_evt = sample_en && neg_v;
    assign cand      = {pal_cand, frame_id ^ neg_h};

    state_t     state;
    state_t     state_nx;
    logic [3:0] match_cnt;
    logic [3:0] match_nx;
    logic [3:0] match_inc;
    logic [1:0] held;
    logic [1:0] held_nx;
    logic       commit;

    assign match_inc = match_cnt + 4'd1;

    always_comb begin
        state_nx = state;
        match_nx = match_cnt;
        held_nx  = held;
        commit   = 1'b0;
        case (state)
            UNLOCKED: begin
                if (field_evt) begin
                    held_nx  = cand;
                    match_nx = 4'd1;
                    if (LOCK_TH <= 4'd1) begin
                        commit   = 1'b1;
                        state_nx = LOCKED;
                    end else begin
                        state_nx = LOCKING;
                    end
                end
            end
            LOCKING: begin
                if (field_evt) begin
                    if (cand == held) begin
                        match_nx = match_inc;
                        if (match_inc >= LOCK_TH) begin
                            commit   = 1'b1;
                            state_nx = LOCKED;
                        end
                    end else begin
                        held_nx  = cand;
                        match_nx = 4'd1;
                    end
                end
            end
            LOCKED: begin
                // A disagreeing field re-arms the filter; the committed value is kept meanwhile.
                if (field_evt && (cand != vinfo_o)) begin
                    held_nx  = cand;
                    match_nx = 4'd1;
                    state_nx = LOCKING;
                end
            end
            default: begin
                state_nx = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            state          <= UNLOCKED;
            match_cnt      <= 4'd0;
            held           <= VINFO_RST;
            vinfo_o        <= VINFO_RST;
            vinfo_locked_o <= 1'b0;
            vinfo_chg_o    <= 1'b0;
        end else begin
            state          <= state_nx;
            match_cnt      <= match_nx;
            held           <= held_nx;
            vinfo_locked_o <= (state_nx == LOCKED);
            vinfo_chg_o    <= commit && (held_nx != vinfo_o);
            if (commit) begin
                vinfo_o <= held_nx;
            end
        end
    end

`ifdef N64_VINFO_LINECNT_EN
    always_ff @(posedge VCLK) begin
        if (RST) begin
            field_lines_o <= '0;
        end else if (sample_en && pos_v) begin
            field_lines_o <= line_cnt;
        end
    end
`else
    assign field_lines_o = '0;
`endif

endmodule

// File: tb/tb_n64_vtiming_ext.sv
// tb/tb_n64_vtiming_ext.sv - self-checking bench for n64_vtiming_ext
module tb_n64_vtiming_ext;

    logic       clk = 1'b0;
    logic       rst;
    logic       nvdsync;
    logic [3:0] spre;
    logic [3:0] scur;

    logic [1:0] vinfo;
    logic       locked;
    logic       chg;
    logic [9:0] flines;
    logic [1:0] v8_vinfo;
    logic       v8_locked;
    logic       v8_chg;
    logic [7:0] v8_lines;
    logic [1:0] v1_vinfo;
    logic       v1_locked;
    logic       v1_chg;
    logic [9:0] v1_lines;

    always #5 clk = ~clk;

    n64_vtiming_ext dut (
        .VCLK(clk), .RST(rst), .nVDSYNC(nvdsync), .Sync_pre(spre), .Sync_cur(scur),
        .vinfo_o(vinfo), .vinfo_locked_o(locked), .vinfo_chg_o(chg), .field_lines_o(flines)
    );

    n64_vtiming_ext #(.LINE_CNT_W(8)) dut8 (
        .VCLK(clk), .RST(rst), .nVDSYNC(nvdsync), .Sync_pre(spre), .Sync_cur(scur),
        .vinfo_o(v8_vinfo), .vinfo_locked_o(v8_locked), .vinfo_chg_o(v8_chg), .field_lines_o(v8_lines)
    );

    n64_vtiming_ext #(.LOCK_FRAMES(1)) dut1 (
        .VCLK(clk), .RST(rst), .nVDSYNC(nvdsync), .Sync_pre(spre), .Sync_cur(scur),
        .vinfo_o(v1_vinfo), .vinfo_locked_o(v1_locked), .vinfo_chg_o(v1_chg), .field_lines_o(v1_lines)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] vinfo;
        logic       locked;
        logic       chg;
        int         lines;
    } exp_t;

    typedef struct {
        int         nlines;
        logic       coinc;
        logic [1:0] vinfo;
        logic       locked;
        logic       chg;
    } vec_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_lines(input int n);
`ifdef N64_VINFO_LINECNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic step(input logic [3:0] p, input logic [3:0] c, input logic nvd);
        @(negedge clk);
        spre    = p;
        scur    = c;
        nvdsync = nvd;
        @(posedge clk);
        #1;
    endtask

    task automatic line();
        step(4'b1000, 4'b1010, 1'b0);
    endtask

    task automatic posv();
        step(4'b0000, 4'b1000, 1'b0);
    endtask

    // n lines, end-of-vsync, then the field event that the scoreboard scores
    task automatic field(input int n, input logic coinc, input logic [1:0] ev,
                         input logic el, input logic ec);
        exp_t e;
        for (int i = 0; i < n; i++) line();
        posv();
        e.vinfo  = ev;
        e.locked = el;
        e.chg    = ec;
        e.lines  = exp_lines(n);
        exp_q.push_back(e);
        step(coinc ? 4'b1010 : 4'b1000, 4'b0000, 1'b0);
    endtask

    // A qualified pos_H is presented throughout reset; reset must win.
    task automatic pulse_reset(input int n);
        @(negedge clk);
        rst     = 1'b1;
        nvdsync = 1'b0;
        spre    = 4'b1000;
        scur    = 4'b1010;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_vinfo", int'(vinfo), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_chg", int'(chg), 0);
        chk("rst_lines", int'(flines), 0);
        chk("rst_line_cnt", int'(dut.line_cnt), 0);
        @(negedge clk);
        rst     = 1'b0;
        nvdsync = 1'b1;
    endtask

    int ev_idx = 0;

    always @(posedge clk) begin
        if (!rst && !nvdsync && spre[3] && !scur[3]) begin
            exp_t e;
            #2;
            if (exp_q.size() == 0) begin
                chk($sformatf("ev%0d_sb_underflow", ev_idx), 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("ev%0d_vinfo", ev_idx), int'(vinfo), int'(e.vinfo));
                chk($sformatf("ev%0d_locked", ev_idx), int'(locked), int'(e.locked));
                chk($sformatf("ev%0d_chg", ev_idx), int'(chg), int'(e.chg));
                chk($sformatf("ev%0d_lines", ev_idx), int'(flines), e.lines);
            end
            ev_idx++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [0:14];
        tbl = '{
            '{263, 1'b0, 2'b01, 1'b0, 1'b0},
            '{263, 1'b0, 2'b01, 1'b0, 1'b0},
            '{263, 1'b0, 2'b00, 1'b1, 1'b1},
            '{312, 1'b1, 2'b00, 1'b0, 1'b0},
            '{313, 1'b0, 2'b00, 1'b0, 1'b0},
            '{312, 1'b1, 2'b11, 1'b1, 1'b1},
            '{263, 1'b0, 2'b11, 1'b0, 1'b0},
            '{263, 1'b0, 2'b11, 1'b0, 1'b0},
            '{263, 1'b0, 2'b11, 1'b0, 1'b0},
            '{263, 1'b0, 2'b00, 1'b1, 1'b1},
            '{313, 1'b0, 2'b00, 1'b0, 1'b0},
            '{263, 1'b0, 2'b00, 1'b0, 1'b0},
            '{263, 1'b0, 2'b00, 1'b0, 1'b0},
            '{263, 1'b0, 2'b00, 1'b1, 1'b0},
            '{263, 1'b0, 2'b00, 1'b1, 1'b0}
        };
        rst     = 1'b1;
        nvdsync = 1'b1;
        spre    = 4'b1000;
        scur    = 4'b1000;
        pulse_reset(3);

        for (int i = 0; i <= 14; i++)
            field(tbl[i].nlines, tbl[i].coinc, tbl[i].vinfo, tbl[i].locked, tbl[i].chg);

        // Reset after two matching fields and again mid-field: partial progress is discarded.
        pulse_reset(1);
        field(263, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("lock1_locked", int'(v1_locked), 1);
        chk("lock1_vinfo", int'(v1_vinfo), 0);
        chk("lock1_chg", int'(v1_chg), 1);
        field(263, 1'b0, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) line();
        pulse_reset(1);
        field(263, 1'b0, 2'b01, 1'b0, 1'b0);
        field(263, 1'b0, 2'b01, 1'b0, 1'b0);
        field(263, 1'b0, 2'b00, 1'b1, 1'b1);

        // Unqualified sample carrying neg_V and pos_H: nothing moves, chg drops.
        step(4'b1000, 4'b0010, 1'b1);
        chk("hold_chg", int'(chg), 0);
        chk("hold_vinfo", int'(vinfo), 0);
        chk("hold_locked", int'(locked), 1);
        chk("hold_line_cnt", int'(dut.line_cnt), 0);

        // pos_V beats pos_H, then the PAL threshold boundary and 8-bit saturation.
        pulse_reset(1);
        for (int i = 0; i < 5; i++) line();
        step(4'b0000, 4'b1010, 1'b0);
        chk("coinc_line_cnt", int'(dut.line_cnt), 0);
        chk("coinc_pal", int'(dut.pal_cand), 0);
        for (int i = 0; i < 287; i++) line();
        posv();
        chk("th287_pal", int'(dut.pal_cand), 0);
        chk("th287_lines", int'(flines), exp_lines(287));
        for (int i = 0; i < 288; i++) line();
        posv();
        chk("th288_pal", int'(dut.pal_cand), 1);
        chk("th288_lines", int'(flines), exp_lines(288));
        for (int i = 0; i < 300; i++) line();
        chk("w10_line_cnt", int'(dut.line_cnt), 300);
        chk("w8_line_cnt_sat", int'(dut8.line_cnt), 255);
        posv();
        chk("w10_pal", int'(dut.pal_cand), 1);
        chk("w8_pal", int'(dut8.pal_cand), 0);

        repeat (4) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
